// File: rtl/calc_pkg.sv
// Shared opcode, error-code and state definitions for the calculator ALU sequencer.
package calc_pkg;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_OPC  = 2'd1;
    localparam logic [1:0] ERR_DIV0 = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_DIV);
    endfunction

endpackage

// File: rtl/calc_tmo_timer.sv
// Busy-phase watchdog: counts enabled cycles and flags the last allowed one.
module calc_tmo_timer #(
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    assign expire = enable && (cnt_q == TMR_W'(TIMEOUT - 1));

    // Saturate at the expiry value so a stalled FSM can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/calc_alu_seq.sv
// Single-outstanding sequencer: parsed command in, ALU start/operands out,
// result plus error code handed to the TX formatter.
module calc_alu_seq
    import calc_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int TMR_W   = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_src1,
    input  logic [15:0] cmd_src2,
    output logic [3:0]  start_alu,
    output logic [15:0] alu_src1,
    output logic [15:0] alu_src2,
    input  logic        alu_done,
    input  logic [31:0] alu_res,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [1:0]  res_err
);

    state_e      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [3:0]  start_alu_q, start_alu_d;
    logic [15:0] alu_src1_q, alu_src1_d;
    logic [15:0] alu_src2_q, alu_src2_d;
    logic        res_valid_q, res_valid_d;
    logic [31:0] res_data_q, res_data_d;
    logic [1:0]  res_err_q, res_err_d;
    logic        tmo_expire;

    calc_tmo_timer #(
        .TIMEOUT (TIMEOUT),
        .TMR_W   (TMR_W)
    ) u_tmo (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (state_q != ST_BUSY),
        .enable (state_q == ST_BUSY),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        start_alu_d = start_alu_q;
        alu_src1_d  = alu_src1_q;
        alu_src2_d  = alu_src2_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (!op_is_valid(cmd_op)) begin
                        state_d     = ST_RESP;
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        res_err_d   = ERR_OPC;
                    end else if (cmd_op == OP_DIV && cmd_src2 == 16'd0) begin
                        state_d     = ST_RESP;
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        res_err_d   = ERR_DIV0;
                    end else begin
                        state_d     = ST_BUSY;
                        start_alu_d = cmd_op;
                        alu_src1_d  = cmd_src1;
                        alu_src2_d  = cmd_src2;
                    end
                end
            end
            ST_BUSY: begin
                // A done arriving on the expiry cycle still counts as success.
                if (alu_done) begin
                    state_d     = ST_RESP;
                    start_alu_d = 4'd0;
                    res_valid_d = 1'b1;
                    res_data_d  = alu_res;
                    res_err_d   = ERR_OK;
                end else if (tmo_expire) begin
                    state_d     = ST_RESP;
                    start_alu_d = 4'd0;
                    res_valid_d = 1'b1;
                    res_data_d  = '0;
                    res_err_d   = ERR_TMO;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d     = ST_IDLE;
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                start_alu_d = 4'd0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            start_alu_q <= 4'd0;
            alu_src1_q  <= '0;
            alu_src2_q  <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            start_alu_q <= start_alu_d;
            alu_src1_q  <= alu_src1_d;
            alu_src2_q  <= alu_src2_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign start_alu = start_alu_q;
    assign alu_src1  = alu_src1_q;
    assign alu_src2  = alu_src2_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed bench for calc_alu_seq with a transaction-level reference model.
module tb_calc_alu_seq;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_src1;
    logic [15:0] cmd_src2;
    logic [3:0]  start_alu;
    logic [15:0] alu_src1;
    logic [15:0] alu_src2;
    logic        alu_done;
    logic [31:0] alu_res;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    calc_alu_seq #(.TIMEOUT(TIMEOUT), .TMR_W(16)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src1  (cmd_src1),
        .cmd_src2  (cmd_src2),
        .start_alu (start_alu),
        .alu_src1  (alu_src1),
        .alu_src2  (alu_src2),
        .alu_done  (alu_done),
        .alu_res   (alu_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: one operation in flight, outcome decided by opcode
    // legality, divisor, ALU done, or the number of cycles spent waiting.
    logic        m_live = 1'b0;
    logic        m_ready, m_valid;
    logic [3:0]  m_start;
    logic [15:0] m_s1, m_s2;
    logic [31:0] m_data;
    logic [1:0]  m_err;
    int          m_waited;

    always @(posedge clk) begin
        if (!n_rst) begin
            m_live = 1'b1; m_ready = 1'b1; m_valid = 1'b0; m_start = 4'd0;
            m_s1 = 16'd0; m_s2 = 16'd0; m_data = 32'd0; m_err = 2'd0; m_waited = 0;
        end else if (m_live) begin
            if (m_ready) begin
                if (cmd_valid) begin
                    m_ready = 1'b0;
                    if (cmd_op == 4'd0 || cmd_op > 4'd4) begin
                        m_valid = 1'b1; m_data = 32'd0; m_err = 2'd1;
                    end else if (cmd_op == 4'd4 && cmd_src2 == 16'd0) begin
                        m_valid = 1'b1; m_data = 32'd0; m_err = 2'd2;
                    end else begin
                        m_start = cmd_op; m_s1 = cmd_src1; m_s2 = cmd_src2; m_waited = 0;
                    end
                end
            end else if (m_start != 4'd0) begin
                m_waited++;
                if (alu_done) begin
                    m_valid = 1'b1; m_data = alu_res; m_err = 2'd0; m_start = 4'd0;
                end else if (m_waited == TIMEOUT) begin
                    m_valid = 1'b1; m_data = 32'd0; m_err = 2'd3; m_start = 4'd0;
                end
            end else if (m_valid && res_ready) begin
                m_valid = 1'b0; m_ready = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_live) begin
                chk("mdl_cmd_ready", 32'(cmd_ready), 32'(m_ready));
                chk("mdl_start_alu", 32'(start_alu), 32'(m_start));
                chk("mdl_res_valid", 32'(res_valid), 32'(m_valid));
                if (m_start != 4'd0) begin
                    chk("mdl_alu_src1", 32'(alu_src1), 32'(m_s1));
                    chk("mdl_alu_src2", 32'(alu_src2), 32'(m_s2));
                end
                if (m_valid) begin
                    chk("mdl_res_data", res_data, m_data);
                    chk("mdl_res_err", 32'(res_err), 32'(m_err));
                end
            end
        end
    end

    // done_at: BUSY cycle (1-based) on which alu_done is driven, 0 = never.
    task automatic do_cmd(input string name, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input int done_at, input logic [31:0] r,
                          input int stall, input logic [1:0] exp_err,
                          input logic [31:0] exp_data, input int exp_busy, input int exp_lat);
        int w;
        int lat;
        int busy;
        cmd_valid = 1'b1; cmd_op = op; cmd_src1 = a; cmd_src2 = b;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk({name, "_accept_timeout"}, 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        busy = 0;
        while (!res_valid && lat <= TIMEOUT + 8) begin
            busy++;
            chk({name, "_busy_start"}, 32'(start_alu), 32'(op));
            alu_done = (busy == done_at);
            alu_res = r;
            @(negedge clk);
            lat++;
        end
        alu_done = 1'b0;
        if (!res_valid) begin
            chk({name, "_result_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({name, "_err"}, 32'(res_err), 32'(exp_err));
        chk({name, "_data"}, res_data, exp_data);
        chk({name, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_start_idle"}, 32'(start_alu), 32'd0);
        for (int i = 0; i < stall; i++) begin
            cmd_valid = 1'b1; cmd_op = 4'd1; cmd_src1 = 16'h1111; cmd_src2 = 16'h2222;
            chk({name, "_hold_valid"}, 32'(res_valid), 32'd1);
            chk({name, "_hold_data"}, res_data, exp_data);
            chk({name, "_hold_ready"}, 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({name, "_post_valid"}, 32'(res_valid), 32'd0);
        chk({name, "_post_start"}, 32'(start_alu), 32'd0);
        chk({name, "_post_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        n_rst = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_src1 = 16'd0; cmd_src2 = 16'd0;
        alu_done = 1'b0; alu_res = 32'd0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_start_alu", 32'(start_alu), 32'd0);
        chk("rst_alu_src1", 32'(alu_src1), 32'd0);
        chk("rst_alu_src2", 32'(alu_src2), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_err", 32'(res_err), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        do_cmd("add",      4'd1, 16'h0009, 16'h0001, 2,  32'h0000_000A, 0, 2'd0, 32'h0000_000A, 2,  3);
        do_cmd("add_fast", 4'd1, 16'h0002, 16'h0003, 1,  32'h0000_0005, 0, 2'd0, 32'h0000_0005, 1,  2);
        do_cmd("bad_op",   4'd5, 16'h0005, 16'h0003, 1,  32'hFFFF_FFFF, 0, 2'd1, 32'h0000_0000, 0,  1);
        do_cmd("bad_op0",  4'd0, 16'h0001, 16'h0001, 1,  32'hFFFF_FFFF, 0, 2'd1, 32'h0000_0000, 0,  1);
        do_cmd("div0",     4'd4, 16'h0006, 16'h0000, 1,  32'hFFFF_FFFF, 0, 2'd2, 32'h0000_0000, 0,  1);
        do_cmd("div",      4'd4, 16'h0006, 16'h0002, 3,  32'h0000_0003, 0, 2'd0, 32'h0000_0003, 3,  4);
        do_cmd("tmo",      4'd2, 16'h0001, 16'h0003, 0,  32'h0000_0000, 0, 2'd3, 32'h0000_0000, 16, 17);
        do_cmd("tmo_done", 4'd2, 16'h0001, 16'h0003, 16, 32'hFFFF_FFFE, 0, 2'd0, 32'hFFFF_FFFE, 16, 17);
        do_cmd("mul_bp",   4'd3, 16'h0100, 16'h0100, 2,  32'h0001_0000, 5, 2'd0, 32'h0001_0000, 2,  3);

        // Reset while the ALU is running, followed by a stray done.
        cmd_valid = 1'b1; cmd_op = 4'd3; cmd_src1 = 16'h0007; cmd_src2 = 16'h0005;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstbusy_start_before", 32'(start_alu), 32'd3);
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        chk("rstbusy_start", 32'(start_alu), 32'd0);
        chk("rstbusy_valid", 32'(res_valid), 32'd0);
        chk("rstbusy_ready", 32'(cmd_ready), 32'd1);
        alu_done = 1'b1; alu_res = 32'h0000_DEAD;
        @(negedge clk);
        alu_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stray_done_valid", 32'(res_valid), 32'd0);
            @(negedge clk);
        end

        do_cmd("after_rst", 4'd1, 16'h0010, 16'h0020, 2, 32'h0000_0030, 0, 2'd0, 32'h0000_0030, 2, 3);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
